// File: rtl/abcd_seq_pkg.sv
// Shared types and widths for the a/b/c/d vector sequencer.
//   seq_state_t : sequencer FSM states
//   VEC_W       : width of the stimulus vector index
//   CNT_W       : width of the e/f ones counters (16 samples max)
//   HOLD_W      : width of the hold-window counter (HOLD_CYCLES <= 255)
package abcd_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} seq_state_t;

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/abcd_vector_sequencer_hold_timer.sv
// Hold-window timer: counts enabled cycles within one vector's hold window.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   clr  : clear the count (new sweep)
//   en   : advance the count; wraps to 0 after the last cycle of the window
//   last : high while the count equals HOLD_CYCLES-1
module hold_timer
  import abcd_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  assign last = (cnt_q == HOLD_W'(HOLD_CYCLES - 1));

  // Next count: clear wins, otherwise advance and wrap at the window end
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/abcd_vector_sequencer.sv
// Clocked stimulus sweep for a 4-input circuit: steps vec_idx from START_VEC
// to LAST_VEC (wrapping through 15 -> 0), holds each vector HOLD_CYCLES
// unpaused cycles, and counts ones on e_in/f_in at the end of every window.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle sweep request (ignored while busy)
//   pause         : freezes the sweep while high (RUN/PAUSE only)
//   e_in, f_in    : responses from the downstream circuit
//   a, b, c, d    : stimulus, {a,b,c,d} = vec_idx while a vector is applied
//   vec_valid     : a vector is being applied (RUN or PAUSE)
//   vec_idx       : current vector index
//   busy          : RUN or PAUSE
//   done          : sweep finished; held until next start or reset
//   e_ones/f_ones : ones counted during the current or last sweep
module abcd_vector_sequencer
  import abcd_seq_pkg::*;
#(
  parameter int unsigned      HOLD_CYCLES = 10,
  parameter logic [VEC_W-1:0] START_VEC   = 4'd0,
  parameter logic [VEC_W-1:0] LAST_VEC    = 4'd15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             e_in,
  input  logic             f_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             vec_valid,
  output logic [VEC_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] e_ones,
  output logic [CNT_W-1:0] f_ones
);

  seq_state_t       state_q, state_d;
  logic [VEC_W-1:0] vec_idx_q, vec_idx_d;
  logic [VEC_W-1:0] abcd_q, abcd_d;
  logic [CNT_W-1:0] e_ones_q, e_ones_d;
  logic [CNT_W-1:0] f_ones_q, f_ones_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             timer_clr;
  logic             timer_en;
  logic             timer_last;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .last (timer_last)
  );

  // Next-state, index and counter logic; flag outputs follow the next state
  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    e_ones_d  = e_ones_q;
    f_ones_d  = f_ones_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          vec_idx_d = START_VEC;
          e_ones_d  = '0;
          f_ones_d  = '0;
          timer_clr = 1'b1;
        end
      end
      RUN: begin
        if (pause) begin
          // Freeze takes priority, even on the sampling cycle
          state_d = PAUSE;
        end else begin
          timer_en = 1'b1;
          if (timer_last) begin
            e_ones_d = e_ones_q + CNT_W'(e_in);
            f_ones_d = f_ones_q + CNT_W'(f_in);
            if (vec_idx_q == LAST_VEC) begin
              state_d = DONE;
            end else begin
              vec_idx_d = vec_idx_q + VEC_W'(1);
            end
          end
        end
      end
      PAUSE: begin
        if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == RUN) || (state_d == PAUSE);
    valid_d = busy_d;
    done_d  = (state_d == DONE);
    abcd_d  = valid_d ? vec_idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_idx_q <= '0;
      abcd_q    <= '0;
      e_ones_q  <= '0;
      f_ones_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      abcd_q    <= abcd_d;
      e_ones_q  <= e_ones_d;
      f_ones_q  <= f_ones_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign a         = abcd_q[3];
  assign b         = abcd_q[2];
  assign c         = abcd_q[1];
  assign d         = abcd_q[0];
  assign vec_valid = valid_q;
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign e_ones    = e_ones_q;
  assign f_ones    = f_ones_q;

endmodule

// File: tb/tb_abcd_vector_sequencer.sv
// Bench for abcd_vector_sequencer: three instances with different sweep
// parameters, hand sequences for the corner cases, a vector table for the
// wrapping sweep, and a randomized run against a reference model.
module tb_abcd_vector_sequencer;

  localparam int H1 = 2;
  localparam int S1 = 0;
  localparam int L1 = 15;
  localparam int N1 = ((L1 - S1 + 16) % 16) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, e_in, f_in;
  logic start1, pause1, start2, pause2, start3, pause3;

  logic a1, b1, c1, d1, vv1, busy1, done1;
  logic [3:0] idx1;
  logic [4:0] eo1, fo1;
  logic a2, b2, c2, d2, vv2, busy2, done2;
  logic [3:0] idx2;
  logic [4:0] eo2, fo2;
  logic a3, b3, c3, d3, vv3, busy3, done3;
  logic [3:0] idx3;
  logic [4:0] eo3, fo3;

  abcd_vector_sequencer #(.HOLD_CYCLES(H1), .START_VEC(4'd0), .LAST_VEC(4'd15)) u_full (
    .clk(clk), .rst(rst), .start(start1), .pause(pause1), .e_in(e_in), .f_in(f_in),
    .a(a1), .b(b1), .c(c1), .d(d1), .vec_valid(vv1), .vec_idx(idx1),
    .busy(busy1), .done(done1), .e_ones(eo1), .f_ones(fo1));

  abcd_vector_sequencer #(.HOLD_CYCLES(1), .START_VEC(4'd14), .LAST_VEC(4'd1)) u_wrap (
    .clk(clk), .rst(rst), .start(start2), .pause(pause2), .e_in(e_in), .f_in(f_in),
    .a(a2), .b(b2), .c(c2), .d(d2), .vec_valid(vv2), .vec_idx(idx2),
    .busy(busy2), .done(done2), .e_ones(eo2), .f_ones(fo2));

  abcd_vector_sequencer #(.HOLD_CYCLES(3), .START_VEC(4'd0), .LAST_VEC(4'd15)) u_pause (
    .clk(clk), .rst(rst), .start(start3), .pause(pause3), .e_in(e_in), .f_in(f_in),
    .a(a3), .b(b3), .c(c3), .d(d3), .vec_valid(vv3), .vec_idx(idx3),
    .busy(busy3), .done(done3), .e_ones(eo3), .f_ones(fo3));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       start;
    logic [3:0] abcd;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } wrap_vec_t;

  wrap_vec_t tbl[7];

  // Reference model state for the randomized run
  bit      m_active, m_paused, m_fin;
  int      m_t, m_e, m_f;
  logic [3:0] m_idx, exp_idx;
  logic [20:0] expv, actv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, run2;

    tbl[0] = '{1'b1, 4'hE, 4'hE, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'h1, 4'h1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'h0, 4'h1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 4'hE, 4'hE, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0};

    rst = 1'b1; e_in = 1'b1; f_in = 1'b1;
    start1 = 1'b0; pause1 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
    start3 = 1'b0; pause3 = 1'b0;
    @(negedge clk);

    // Reset values
    step(); step();
    chk("rst_idx", 32'(idx1), 32'd0);
    chk("rst_abcd", 32'({a1, b1, c1, d1}), 32'd0);
    chk("rst_flags", 32'({vv1, busy1, done1}), 32'd0);
    chk("rst_ones", 32'({eo1, fo1}), 32'd0);
    rst = 1'b0;
    step(); step(); step();
    chk("idle_ones", 32'({eo1, fo1}), 32'd0);
    chk("idle_busy", 32'(busy1), 32'd0);

    // Full sweep, HOLD=2, 0..15, mid-sweep start ignored
    e_in = 1'b0; f_in = 1'b1;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("sweep_idx", 32'(idx1), 32'(i / 2));
      chk("sweep_abcd", 32'({a1, b1, c1, d1}), 32'(i / 2));
      chk("sweep_busy", 32'({busy1, vv1, done1}), 32'b110);
      if (i == 20) chk("sweep_fones_mid", 32'({eo1, fo1}), 32'(10));
      start1 = (i == 9);
      step();
    end
    start1 = 1'b0;
    chk("sweep_done", 32'({busy1, vv1, done1}), 32'b001);
    chk("sweep_fones", 32'(fo1), 32'd16);
    chk("sweep_eones", 32'(eo1), 32'd0);
    chk("sweep_last_idx", 32'(idx1), 32'd15);
    chk("sweep_done_abcd", 32'({a1, b1, c1, d1}), 32'd0);

    // Restart from DONE
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("restart_idx", 32'(idx1), 32'd0);
    chk("restart_flags", 32'({busy1, done1}), 32'b10);
    chk("restart_ones", 32'({eo1, fo1}), 32'd0);

    // Reset mid-sweep during vector 7
    for (int i = 0; i < 40 && idx1 != 4'd7; i++) step();
    chk("reach_vec7", 32'(idx1), 32'd7);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_idx", 32'(idx1), 32'd0);
    chk("midrst_abcd", 32'({a1, b1, c1, d1}), 32'd0);
    chk("midrst_flags", 32'({vv1, busy1, done1}), 32'd0);
    chk("midrst_ones", 32'({eo1, fo1}), 32'd0);
    rst = 1'b1; start1 = 1'b1; step(); rst = 1'b0; start1 = 1'b0;
    chk("rst_beats_start", 32'(busy1), 32'd0);
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("post_rst_start", 32'({busy1, vv1, idx1}), 32'({2'b11, 4'd0}));

    // Wrapping sweep 14..1, HOLD=1, from the vector table
    for (int i = 0; i < 7; i++) begin
      start2 = tbl[i].start;
      step();
      chk($sformatf("wrap_abcd[%0d]", i), 32'({a2, b2, c2, d2}), 32'(tbl[i].abcd));
      chk($sformatf("wrap_idx[%0d]", i), 32'(idx2), 32'(tbl[i].idx));
      chk($sformatf("wrap_flags[%0d]", i), 32'({busy2, done2}), 32'({tbl[i].busy, tbl[i].done}));
    end
    start2 = 1'b0;

    // Pause during vector 2 (hold count 1) giving a 5-cycle freeze
    e_in = 1'b1; f_in = 1'b0;
    start3 = 1'b1; step(); start3 = 1'b0;
    run2 = 0;
    for (k = 0; k < 200; k++) begin
      if (done3) break;
      if (busy3 && idx3 == 4'd2) run2++;
      if (k == 9) begin
        chk("pause_state", 32'({busy3, vv3, idx3}), 32'({2'b11, 4'd2}));
        chk("pause_abcd", 32'({a3, b3, c3, d3}), 32'd2);
      end
      pause3 = (k >= 7 && k <= 10);
      step();
    end
    pause3 = 1'b0;
    chk("pause_vec2_len", 32'(run2), 32'd8);
    chk("pause_total_len", 32'(k), 32'd53);
    chk("pause_ones", 32'({eo3, fo3}), 32'({5'd16, 5'd0}));

    // Randomized run against the reference model
    rst = 1'b1; step(); rst = 1'b0;
    m_active = 0; m_paused = 0; m_fin = 0; m_t = 0; m_e = 0; m_f = 0; m_idx = 4'd0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      exp_idx = m_active ? 4'((S1 + m_t / H1) % 16) : m_idx;
      expv = {m_active, m_active, m_fin, exp_idx, (m_active ? exp_idx : 4'd0), 5'(m_e), 5'(m_f)};
      actv = {busy1, vv1, done1, idx1, a1, b1, c1, d1, eo1, fo1};
      chk("random", 32'(actv), 32'(expv));

      rst    = ($urandom_range(199) == 0);
      start1 = ($urandom_range(99) < 8);
      pause1 = ($urandom_range(99) < 15);
      e_in   = 1'($urandom);
      f_in   = 1'($urandom);

      if (rst) begin
        m_active = 0; m_paused = 0; m_fin = 0; m_t = 0; m_e = 0; m_f = 0; m_idx = 4'd0;
      end else if (!m_active) begin
        if (start1) begin
          m_active = 1; m_paused = 0; m_fin = 0; m_t = 0; m_e = 0; m_f = 0;
        end
      end else if (m_paused) begin
        if (!pause1) m_paused = 0;
      end else if (pause1) begin
        m_paused = 1;
      end else begin
        if (m_t % H1 == H1 - 1) begin
          m_e += int'(e_in);
          m_f += int'(f_in);
        end
        m_t++;
        if (m_t == N1 * H1) begin
          m_active = 0;
          m_fin = 1;
          m_idx = 4'(L1);
        end
      end
      step();
    end
    rst = 1'b0; start1 = 1'b0; pause1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
